// File: rtl/conv_result_collector.sv
// Captures convolver results, rescales/saturates them, tags each with its row-major
// output address and queues {addr,data} for a valid/ready consumer. Optional RELU_EN macro.
module conv_result_collector #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int IN_WIDTH    = 32,
  parameter  int FRAC_BITS   = 8,
  parameter  int IMAGE_SIZE  = 28,
  parameter  int KERNEL_SIZE = 5,
  parameter  int FIFO_DEPTH  = 4,
  localparam int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1,
  localparam int ADDR_W      = $clog2(OUT_SIZE * OUT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [IN_WIDTH-1:0]   conv_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_WIDTH;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OUT_SIZE * OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
    {{(IN_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
    {{(IN_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic signed [IN_WIDTH-1:0] shifted;
  logic signed [IN_WIDTH-1:0] clipped_in;
  logic [DATA_WIDTH-1:0]      sample;
  logic [ENTRY_W-1:0]         head;
  logic                       full, pop, push_ok, drop;

  always_comb begin
    shifted = $signed(conv_in) >>> FRAC_BITS;
`ifdef RELU_EN
    clipped_in = shifted[IN_WIDTH-1] ? '0 : shifted;
`else
    clipped_in = shifted;
`endif
    if (clipped_in > SAT_MAX)      sample = SAT_MAX[DATA_WIDTH-1:0];
    else if (clipped_in < SAT_MIN) sample = SAT_MIN[DATA_WIDTH-1:0];
    else                           sample = clipped_in[DATA_WIDTH-1:0];
  end

  assign full    = (count_q == CNT_FULL);
  assign pop     = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok = enable & (~full | pop);
  assign drop    = enable & full & ~pop;

  always_comb begin
    addr_d       = addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | drop;
    // Position follows the stream even for dropped samples.
    if (enable) begin
      addr_d       = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
      frame_done_d = (addr_q == ADDR_LAST);
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {addr_q, sample};
  end

  // Gate the head so outputs read zero whenever the queue is empty.
  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_addr   = out_valid ? head[ENTRY_W-1:DATA_WIDTH] : '0;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector; expected values are hand-derived.
module tb_conv_result_collector;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [31:0] conv_in;
  logic [15:0] out_data;
  logic [9:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic        overflow;

  int total;
  int bad;

  conv_result_collector dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .conv_in    (conv_in),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    enable    = 1'b0;
    out_ready = 1'b0;
    rstn      = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enable    = 1'($urandom_range(0, 1));
      conv_in   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      total += 5;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      if (out_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0000", out_data); end
      if (out_addr !== 10'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", out_addr); end
      if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    end
    enable    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    enable    = 1'b1;
    conv_in   = 32'h0000_1280;
    out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    if (out_data !== 16'h0012) begin bad++; $display("FAIL single_data got=%h exp=0012", out_data); end
    if (out_addr !== 10'd0) begin bad++; $display("FAIL single_addr got=%0d exp=0", out_addr); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL single_frame_done got=%b exp=0", frame_done); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [31:0] vin [3];
    logic [15:0] vexp [3];
    vin[0] = 32'h0100_0000;
    vin[1] = 32'hFF00_0000;
    vin[2] = 32'hFFFF_FF80;
    vexp[0] = 16'h7FFF;
`ifdef RELU_EN
    vexp[1] = 16'h0000;
    vexp[2] = 16'h0000;
`else
    vexp[1] = 16'h8000;
    vexp[2] = 16'hFFFF;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable    = 1'b1;
      conv_in   = vin[i];
      out_ready = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL sat_valid[%0d] got=%b exp=1", i, out_valid); end
      if (out_data !== vexp[i]) begin bad++; $display("FAIL sat_data[%0d] got=%h exp=%h", i, out_data, vexp[i]); end
      if (out_addr !== 10'(i + 1)) begin bad++; $display("FAIL sat_addr[%0d] got=%0d exp=%0d", i, out_addr, i + 1); end
    end
  endtask

  task automatic test_frame();
    int exp_rd;
    int pulses;
    logic fd_exp;
    exp_rd = 0;
    pulses = 0;
    fd_exp = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc <= 24 * 28; cyc++) begin
      @(negedge clk);
      total++;
      if (frame_done !== fd_exp) begin bad++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, fd_exp); end
      if (frame_done === 1'b1) pulses++;
      if (out_valid === 1'b1) begin
        total += 2;
        if (out_addr !== 10'(exp_rd)) begin bad++; $display("FAIL frame_addr got=%0d exp=%0d", out_addr, exp_rd); end
        if (out_data !== 16'(exp_rd)) begin bad++; $display("FAIL frame_data got=%h exp=%h", out_data, 16'(exp_rd)); end
        exp_rd++;
      end
      if (cyc < 24 * 28 && (cyc % 28) < 24) begin
        enable  = 1'b1;
        conv_in = 32'((cyc / 28) * 24 + (cyc % 28)) << 8;
        fd_exp  = ((cyc / 28) * 24 + (cyc % 28)) == 575;
      end else begin
        enable = 1'b0;
        fd_exp = 1'b0;
      end
    end
    total += 3;
    if (exp_rd !== 576) begin bad++; $display("FAIL frame_count got=%0d exp=576", exp_rd); end
    if (pulses !== 1) begin bad++; $display("FAIL frame_pulses got=%0d exp=1", pulses); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL frame_overflow got=%b exp=0", overflow); end
    enable  = 1'b1;
    conv_in = 32'h0000_0500;
    @(negedge clk);
    enable = 1'b0;
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", out_valid); end
    if (out_addr !== 10'd0) begin bad++; $display("FAIL wrap_addr got=%0d exp=0", out_addr); end
    if (out_data !== 16'h0005) begin bad++; $display("FAIL wrap_data got=%h exp=0005", out_data); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL wrap_frame_done got=%b exp=0", frame_done); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable  = 1'b1;
      conv_in = 32'(i) << 8;
    end
    @(negedge clk);
    enable = 1'b0;
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (out_addr !== 10'd0) begin bad++; $display("FAIL ovf_head got=%0d exp=0", out_addr); end
    @(negedge clk);
    total++;
    if (out_addr !== 10'd0) begin bad++; $display("FAIL ovf_stall_hold got=%0d exp=0", out_addr); end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      total += 2;
      if (out_addr !== 10'(k)) begin bad++; $display("FAIL ovf_drain_addr got=%0d exp=%0d", out_addr, k); end
      if (out_data !== 16'(k)) begin bad++; $display("FAIL ovf_drain_data got=%h exp=%h", out_data, 16'(k)); end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", out_valid); end
    enable  = 1'b1;
    conv_in = 32'h0000_0700;
    @(negedge clk);
    enable = 1'b0;
    total += 3;
    if (out_addr !== 10'd6) begin bad++; $display("FAIL ovf_next_addr got=%0d exp=6", out_addr); end
    if (out_data !== 16'h0007) begin bad++; $display("FAIL ovf_next_data got=%h exp=0007", out_data); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enable  = 1'b1;
      conv_in = 32'(i) << 8;
    end
    @(negedge clk);
    enable    = 1'b1;
    conv_in   = 32'h0000_0400;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      enable = 1'b0;
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL fullpop_valid k=%0d got=%b exp=1", k, out_valid); end
      if (out_addr !== 10'(k)) begin bad++; $display("FAIL fullpop_addr got=%0d exp=%0d", out_addr, k); end
      if (out_data !== 16'(k)) begin bad++; $display("FAIL fullpop_data got=%h exp=%h", out_data, 16'(k)); end
    end
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", out_valid); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      enable  = 1'b1;
      conv_in = 32'(i + 1) << 8;
    end
    @(negedge clk);
    enable = 1'b0;
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b exp=1", out_valid); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL mid_overflow got=%b exp=1", overflow); end
    rstn = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_overflow got=%b exp=0", overflow); end
    if (out_data !== 16'h0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0000", out_data); end
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    enable  = 1'b1;
    conv_in = 32'h0000_2A00;
    @(negedge clk);
    enable = 1'b0;
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_next_valid got=%b exp=1", out_valid); end
    if (out_addr !== 10'd0) begin bad++; $display("FAIL mid_next_addr got=%0d exp=0", out_addr); end
    if (out_data !== 16'h002A) begin bad++; $display("FAIL mid_next_data got=%h exp=002a", out_data); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    enable    = 1'b0;
    conv_in   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_frame();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
